// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the program counter with return-address stack.
//   branch_t   - 3-bit command issued by the decoder each cycle
//   pc_state_t - control FSM state (RUN / HALTED)
package pc_pkg;

    typedef enum logic [2:0] {
        SEQ      = 3'd0,
        JUMP     = 3'd1,
        BR_SHORT = 3'd2,
        BR_LONG  = 3'd3,
        CALL     = 3'd4,
        RET      = 3'd5,
        HALT     = 3'd6,
        RSVD     = 3'd7
    } branch_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_ras_stack.sv
// pc_ras_stack: circular LIFO of return addresses.
//   clk, reset   - clock, synchronous active-high reset (clears count/pointer)
//   push_i       - write data_i on top; when full the oldest entry is overwritten
//   pop_i        - drop the top entry (ignored when empty)
//   data_i       - address to push
//   top_o        - most recently pushed valid entry
//   count_o      - number of valid entries, saturates at RAS_DEPTH
//   full_o/empty_o - occupancy status
// push_i and pop_i are never asserted together by the top level.
module pc_ras_stack #(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [AW-1:0]                data_i,
    output logic [AW-1:0]                top_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q;   // next slot to write; wraps naturally (power-of-two depth)
    logic [CW-1:0] count_q;

    assign full_o  = (count_q == CW'(RAS_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign top_o   = mem_q[ptr_q - PW'(1)];

    // Writing at ptr_q when full lands on the oldest entry, giving overwrite-on-full.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push_i) begin
            ptr_q <= ptr_q + PW'(1);
            if (!full_o) count_q <= count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            ptr_q   <= ptr_q - PW'(1);
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/pc_ras.sv
// pc_ras: parametrised program counter with hardware return-address stack.
//   clk, reset        - clock, synchronous active-high reset (beats stall and commands)
//   stall_i           - hold all state, ignore command
//   flag_i            - conditional branches taken when low
//   branch_type_i     - command (pc_pkg::branch_t)
//   start_address_i   - reset vector
//   abs_address_i     - JUMP / CALL target
//   short_offset_i, long_offset_i - signed branch offsets
//   address_o         - registered fetch address
//   ras_count_o       - valid stack entries
//   ras_overflow_o, ras_underflow_o - sticky, cleared only by reset
//   halted_o          - in HALTED state (left only by reset)
// Optional macro PC_TRACE_EN adds prev_address_o and taken_o.
module pc_ras
    import pc_pkg::*;
#(
    parameter int AW        = 8,
    parameter int SHORT_W   = 3,
    parameter int LONG_W    = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall_i,
    input  logic                        flag_i,
    input  logic [2:0]                  branch_type_i,
    input  logic [AW-1:0]               start_address_i,
    input  logic [AW-1:0]               abs_address_i,
    input  logic [SHORT_W-1:0]          short_offset_i,
    input  logic [LONG_W-1:0]           long_offset_i,
    output logic [AW-1:0]               address_o,
    output logic [$clog2(RAS_DEPTH):0]  ras_count_o,
    output logic                        ras_overflow_o,
    output logic                        ras_underflow_o,
`ifdef PC_TRACE_EN
    output logic [AW-1:0]               prev_address_o,
    output logic                        taken_o,
`endif
    output logic                        halted_o
);
    pc_state_t     state_q, state_d;
    logic [AW-1:0] address_q, address_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          push, pop, accept;
    logic          stk_full, stk_empty;
    logic [AW-1:0] stk_top, addr_inc, addr_short, addr_long;
    branch_t       cmd;

    assign cmd        = branch_t'(branch_type_i);
    assign accept     = !stall_i && (state_q == RUN);
    assign addr_inc   = address_q + AW'(1);
    // Sized cast of a signed operand sign-extends; the sum wraps mod 2^AW.
    assign addr_short = address_q + AW'($signed(short_offset_i));
    assign addr_long  = address_q + AW'($signed(long_offset_i));

    pc_ras_stack #(.AW(AW), .RAS_DEPTH(RAS_DEPTH)) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (addr_inc),
        .top_o   (stk_top),
        .count_o (ras_count_o),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (accept) begin
            case (cmd)
                JUMP:     address_d = abs_address_i;
                BR_SHORT: address_d = flag_i ? addr_inc : addr_short;
                BR_LONG:  address_d = flag_i ? addr_inc : addr_long;
                CALL: begin
                    push      = 1'b1;
                    address_d = abs_address_i;
                    if (stk_full) ovf_d = 1'b1;
                end
                RET: begin
                    if (!stk_empty) begin
                        pop       = 1'b1;
                        address_d = stk_top;
                    end else begin
                        address_d = addr_inc;
                        unf_d     = 1'b1;
                    end
                end
                HALT:    state_d   = HALTED;
                default: address_d = addr_inc;  // SEQ and reserved
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            address_q <= start_address_i;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign address_o       = address_q;
    assign ras_overflow_o  = ovf_q;
    assign ras_underflow_o = unf_q;
    assign halted_o        = (state_q == HALTED);

`ifdef PC_TRACE_EN
    logic [AW-1:0] prev_address_q;
    logic          taken_q, redirect;

    assign redirect = accept && ((cmd == JUMP) || (cmd == CALL) ||
                                 ((cmd == RET) && !stk_empty) ||
                                 (((cmd == BR_SHORT) || (cmd == BR_LONG)) && !flag_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_address_q <= '0;
            taken_q        <= 1'b0;
        end else begin
            if (accept) prev_address_q <= address_q;
            taken_q <= redirect;
        end
    end

    assign prev_address_o = prev_address_q;
    assign taken_o        = taken_q;
`endif

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: scoreboard bench for pc_ras (AW=8, SHORT_W=3, LONG_W=6, RAS_DEPTH=4).
module tb_pc_ras;
    logic       clk = 1'b0;
    logic       reset, stall, flag;
    logic [2:0] btype;
    logic [7:0] start_a, abs_a;
    logic [2:0] soff;
    logic [5:0] loff;
    logic [7:0] address;
    logic [2:0] ras_count;
    logic       ovf, unf, halted;
`ifdef PC_TRACE_EN
    logic [7:0] prev_address;
    logic       taken;
`endif

    always #5 clk = ~clk;

    pc_ras #(.AW(8), .SHORT_W(3), .LONG_W(6), .RAS_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall),
        .flag_i          (flag),
        .branch_type_i   (btype),
        .start_address_i (start_a),
        .abs_address_i   (abs_a),
        .short_offset_i  (soff),
        .long_offset_i   (loff),
        .address_o       (address),
        .ras_count_o     (ras_count),
        .ras_overflow_o  (ovf),
        .ras_underflow_o (unf),
`ifdef PC_TRACE_EN
        .prev_address_o  (prev_address),
        .taken_o         (taken),
`endif
        .halted_o        (halted)
    );

    typedef struct {
        logic [7:0] addr;
        int         cnt;
        logic       ovf;
        logic       unf;
        logic       hlt;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_err = 0;

    // reference model: unbounded queue trimmed from the front on overflow
    logic [7:0] m_addr;
    logic [7:0] m_stk[$];
    logic       m_ovf, m_unf, m_hlt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic s, input logic f, input logic [2:0] c,
                         input logic [7:0] sa, input logic [7:0] a,
                         input logic [2:0] so, input logic [5:0] lo);
        if (r) begin
            m_addr = sa; m_stk.delete(); m_ovf = 0; m_unf = 0; m_hlt = 0;
        end else if (!s && !m_hlt) begin
            case (c)
                3'd1: m_addr = a;
                3'd2: m_addr = f ? m_addr + 8'd1 : m_addr + 8'($signed(so));
                3'd3: m_addr = f ? m_addr + 8'd1 : m_addr + 8'($signed(lo));
                3'd4: begin
                    m_stk.push_back(m_addr + 8'd1);
                    if (m_stk.size() > 4) begin
                        void'(m_stk.pop_front());
                        m_ovf = 1;
                    end
                    m_addr = a;
                end
                3'd5: begin
                    if (m_stk.size() > 0) m_addr = m_stk.pop_back();
                    else begin m_addr = m_addr + 8'd1; m_unf = 1; end
                end
                3'd6: m_hlt = 1;
                default: m_addr = m_addr + 8'd1;
            endcase
        end
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic f,
                        input logic [2:0] c, input logic [7:0] a,
                        input logic [2:0] so, input logic [5:0] lo);
        exp_t e;
        @(negedge clk);
        reset = r; stall = s; flag = f; btype = c; abs_a = a; soff = so; loff = lo;
        model(r, s, f, c, start_a, a, so, lo);
        e.addr = m_addr; e.cnt = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf; e.hlt = m_hlt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".addr"},  32'(address),   32'(e.addr));
        chk({tag, ".count"}, 32'(ras_count), 32'(e.cnt));
        chk({tag, ".ovf"},   32'(ovf),       32'(e.ovf));
        chk({tag, ".unf"},   32'(unf),       32'(e.unf));
        chk({tag, ".halt"},  32'(halted),    32'(e.hlt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; stall = 0; flag = 0; btype = 0; abs_a = 0; soff = 0; loff = 0;
        start_a = 8'h10;
        m_addr = 0; m_ovf = 0; m_unf = 0; m_hlt = 0;

        step("rst", 1, 0, 0, 3'd0, 8'h00, 3'd0, 6'd0);
        chk("rst.plan", 32'(address), 32'h10);
        for (int i = 0; i < 3; i++) step("seq", 0, 0, 0, 3'd0, 8'h00, 3'd0, 6'd0);
        chk("seq.plan", 32'(address), 32'h13);

        step("jmp20", 0, 0, 0, 3'd1, 8'h20, 3'd0, 6'd0);
        step("brs_tk", 0, 0, 0, 3'd2, 8'h00, 3'b101, 6'd0);   // -3
        chk("brs_tk.plan", 32'(address), 32'h1D);
        step("brs_nt", 0, 0, 1, 3'd2, 8'h00, 3'b101, 6'd0);
        chk("brs_nt.plan", 32'(address), 32'h1E);
        step("jmpF0", 0, 0, 0, 3'd1, 8'hF0, 3'd0, 6'd0);
        step("brl_wrap", 0, 0, 0, 3'd3, 8'h00, 3'd0, 6'd31);
        chk("brl_wrap.plan", 32'(address), 32'h0F);
        step("rsvd", 0, 0, 0, 3'd7, 8'h55, 3'd0, 6'd0);

        step("jmp05", 0, 0, 0, 3'd1, 8'h05, 3'd0, 6'd0);
        step("call40", 0, 0, 0, 3'd4, 8'h40, 3'd0, 6'd0);
        step("seq41", 0, 0, 0, 3'd0, 8'h00, 3'd0, 6'd0);
        step("ret06", 0, 0, 0, 3'd5, 8'h00, 3'd0, 6'd0);
        chk("ret06.plan", 32'(address), 32'h06);

        for (int i = 0; i < 5; i++)
            step("callN", 0, 0, 0, 3'd4, 8'(8'h80 + 8'(i * 16)), 3'd0, 6'd0);
        chk("ovf.plan", 32'(ovf), 32'd1);
        for (int i = 0; i < 4; i++) step("retN", 0, 0, 0, 3'd5, 8'h00, 3'd0, 6'd0);
        chk("lifo.plan", 32'(address), 32'h81);
        step("ret_empty", 0, 0, 0, 3'd5, 8'h00, 3'd0, 6'd0);
        chk("unf.plan", 32'(address), 32'h82);

        for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 3'd1, 8'h33, 3'd0, 6'd0);
        step("unstall", 0, 0, 0, 3'd1, 8'h33, 3'd0, 6'd0);
        chk("unstall.plan", 32'(address), 32'h33);

        step("call50", 0, 0, 0, 3'd4, 8'h50, 3'd0, 6'd0);
        step("ret_b2b", 0, 0, 0, 3'd5, 8'h00, 3'd0, 6'd0);
        chk("ret_b2b.plan", 32'(address), 32'h34);

        step("halt", 0, 0, 0, 3'd6, 8'h00, 3'd0, 6'd0);
        step("h_jmp", 0, 0, 0, 3'd1, 8'h99, 3'd0, 6'd0);
        step("h_call", 0, 0, 0, 3'd4, 8'hAA, 3'd0, 6'd0);
        step("h_stall", 0, 1, 0, 3'd5, 8'h00, 3'd0, 6'd0);
        chk("halt.plan", 32'(address), 32'h34);
        start_a = 8'h77;
        step("h_rst", 1, 1, 0, 3'd1, 8'h99, 3'd0, 6'd0);
        chk("h_rst.plan", 32'(address), 32'h77);
        step("post_rst", 0, 0, 0, 3'd0, 8'h00, 3'd0, 6'd0);
        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
